// File: rtl/nonce_dispatch_scheduler_if.sv
// Bundle between the nonce scheduler, its hash-core pool and the result consumer.
// Carries batch control, per-core launch/complete signals and the result stream.
// The master side is the scheduler; the slave side is the surrounding logic.
interface nonce_dispatch_scheduler_if #(
  parameter int NUM_CORES = 4
);
  logic                    start;
  logic [31:0]             nonce_base;
  logic                    busy;
  logic                    done;
  logic [NUM_CORES-1:0]    core_start;
  logic [31:0]             core_nonce;
  logic [NUM_CORES-1:0]    core_done;
  logic [NUM_CORES*32-1:0] core_h0;
  logic                    res_valid;
  logic [7:0]              res_idx;
  logic [31:0]             res_data;
  logic                    res_ready;

  modport master (
    input  start, nonce_base, core_done, core_h0, res_ready,
    output busy, done, core_start, core_nonce, res_valid, res_idx, res_data
  );

  modport slave (
    output start, nonce_base, core_done, core_h0, res_ready,
    input  busy, done, core_start, core_nonce, res_valid, res_idx, res_data
  );
endinterface

// File: rtl/nonce_dispatch_scheduler.sv
// Dispatches NUM_NONCES nonces round-robin onto NUM_CORES hash cores, returns (idx, H0) pairs.
// Latency: start->first core_start 1 cycle, core_done->res_valid 1 cycle, last handshake->done 1 cycle.
// Backpressure: res_ready low holds the result stable; cores stay HELD and are not re-dispatched.
module nonce_dispatch_scheduler #(
  parameter int NUM_CORES  = 4,
  parameter int NUM_NONCES = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  nonce_dispatch_scheduler_if.master bus
);

  localparam int            CW        = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [8:0]    NN        = 9'(NUM_NONCES);
  localparam logic [CW-1:0] LAST_CORE = CW'(NUM_CORES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_e;
  typedef enum logic [1:0] {C_FREE, C_RUNNING, C_HELD} core_e;

  state_e               state_q;
  logic [31:0]          base_q;
  logic [8:0]           issued_q, retired_q;
  logic                 busy_q, done_q;

  core_e                cst_q [NUM_CORES];
  core_e                cst_d [NUM_CORES];
  logic [7:0]           cidx_q [NUM_CORES];
  logic [31:0]          ch0_q [NUM_CORES];

  logic [CW-1:0]        disp_ptr_q, drain_ptr_q, res_sel_q, res_sel_d;
  logic                 res_valid_q, res_valid_d;

  logic [NUM_CORES-1:0] disp_vec, cap_vec, held_d;
  logic                 disp_hit, pick_hit, hs;
  logic [CW-1:0]        disp_sel, disp_try, pick_sel, pick_try, pick_from;

  assign hs = res_valid_q & bus.res_ready;

  // Pick the first FREE core after the one launched most recently.
  always_comb begin
    disp_hit = 1'b0;
    disp_sel = disp_ptr_q;
    disp_try = '0;
    disp_vec = '0;
    if (state_q == S_RUN && issued_q < NN) begin
      for (int k = 1; k <= NUM_CORES; k++) begin
        disp_try = CW'((int'(disp_ptr_q) + k) % NUM_CORES);
        if (!disp_hit && cst_q[disp_try] == C_FREE) begin
          disp_hit = 1'b1;
          disp_sel = disp_try;
        end
      end
    end
    if (disp_hit) disp_vec[disp_sel] = 1'b1;
  end

  // Per-core next state: capture, drain and launch touch disjoint cores in one cycle.
  always_comb begin
    cap_vec = '0;
    held_d  = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      cap_vec[i] = (cst_q[i] == C_RUNNING) && bus.core_done[i];
      cst_d[i]   = cst_q[i];
      if (cap_vec[i]) cst_d[i] = C_HELD;
      if (hs && res_sel_q == CW'(i)) cst_d[i] = C_FREE;
      if (disp_vec[i]) cst_d[i] = C_RUNNING;
      held_d[i] = (cst_d[i] == C_HELD);
    end
  end

  // Choose the next result source when the output slot empties; the held one stays put.
  always_comb begin
    pick_from = hs ? res_sel_q : drain_ptr_q;
    pick_hit  = 1'b0;
    pick_sel  = pick_from;
    pick_try  = '0;
    for (int k = 1; k <= NUM_CORES; k++) begin
      pick_try = CW'((int'(pick_from) + k) % NUM_CORES);
      if (!pick_hit && held_d[pick_try]) begin
        pick_hit = 1'b1;
        pick_sel = pick_try;
      end
    end
    res_valid_d = res_valid_q;
    res_sel_d   = res_sel_q;
    if (!res_valid_q || hs) begin
      res_valid_d = pick_hit;
      res_sel_d   = pick_hit ? pick_sel : res_sel_q;
    end
  end

  // Batch FSM with issue/retire counters and registered busy/done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      issued_q  <= '0;
      retired_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_q   <= S_RUN;
            base_q    <= bus.nonce_base;
            issued_q  <= '0;
            retired_q <= '0;
            busy_q    <= 1'b1;
          end
        end
        S_RUN: begin
          issued_q  <= issued_q + 9'(disp_hit);
          retired_q <= retired_q + 9'(hs);
          if (retired_q + 9'(hs) == NN) begin
            state_q <= S_FIN;
            done_q  <= 1'b1;
          end
        end
        S_FIN: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Core slots, round-robin pointers and the output slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        cst_q[i]  <= C_FREE;
        cidx_q[i] <= '0;
        ch0_q[i]  <= '0;
      end
      disp_ptr_q  <= LAST_CORE;
      drain_ptr_q <= LAST_CORE;
      res_sel_q   <= '0;
      res_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        cst_q[i] <= cst_d[i];
        if (disp_vec[i]) cidx_q[i] <= issued_q[7:0];
        if (cap_vec[i])  ch0_q[i]  <= bus.core_h0[32*i +: 32];
      end
      if (disp_hit) disp_ptr_q <= disp_sel;
      if (hs)       drain_ptr_q <= res_sel_q;
      res_valid_q <= res_valid_d;
      res_sel_q   <= res_sel_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.core_start = disp_vec;
  assign bus.core_nonce = disp_hit ? base_q + {23'd0, issued_q} : 32'd0;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_idx    = res_valid_q ? cidx_q[res_sel_q] : 8'd0;
  assign bus.res_data   = res_valid_q ? ch0_q[res_sel_q] : 32'd0;

endmodule

// File: tb/tb_nonce_dispatch_scheduler.sv
// Bench for nonce_dispatch_scheduler: a 4-core/16-nonce instance driven from a vector table
// plus hand sequences (backpressure, mid-batch reset), and a 1-core/3-nonce serial instance.
module tb_nonce_dispatch_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  nonce_dispatch_scheduler_if #(.NUM_CORES(4)) ifa ();
  nonce_dispatch_scheduler_if #(.NUM_CORES(1)) ifb ();

  nonce_dispatch_scheduler #(.NUM_CORES(4), .NUM_NONCES(16)) dut_a (
    .clk(clk), .reset(rst), .bus(ifa)
  );
  nonce_dispatch_scheduler #(.NUM_CORES(1), .NUM_NONCES(3)) dut_b (
    .clk(clk), .reset(rst), .bus(ifb)
  );

  typedef struct {
    logic [31:0] base;
    int          lat;
    int          rmode;
    logic        do_restart;
    logic [31:0] rbase;
    logic [31:0] e0, e1, e2, e3, e15;
  } vec_t;

  function automatic logic [31:0] hfn(input logic [31:0] n);
    return {n[15:0], n[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Core pool model for the 4-core instance: fixed latency, optional hold to align completions.
  int          lat_a = 10;
  logic        hold_a = 1'b0;
  int          cnt_a [4] = '{default: 0};
  logic        pend_a [4] = '{default: 1'b0};
  logic [31:0] nreg_a [4] = '{default: 32'h0};
  logic [31:0] nlog_a [$];
  int          starts_a = 0;

  always @(negedge clk) begin
    ifa.core_done = '0;
    for (int i = 0; i < 4; i++) begin
      if (cnt_a[i] > 0) begin
        cnt_a[i]--;
        if (cnt_a[i] == 0) pend_a[i] = 1'b1;
      end
      if (pend_a[i] && !hold_a) begin
        pend_a[i] = 1'b0;
        ifa.core_done[i] = 1'b1;
        ifa.core_h0[32*i +: 32] = hfn(nreg_a[i]);
      end
      if (ifa.core_start[i]) begin
        nreg_a[i] = ifa.core_nonce;
        cnt_a[i]  = lat_a;
        nlog_a.push_back(ifa.core_nonce);
        starts_a++;
      end
    end
  end

  // Single-core model for the serial instance; logs launch cycle and nonce.
  int          cnt_b = 0;
  logic [31:0] nreg_b = 32'h0;
  int          bs_cyc [$];
  logic [31:0] bs_non [$];

  always @(negedge clk) begin
    ifb.core_done = 1'b0;
    if (cnt_b > 0) begin
      cnt_b--;
      if (cnt_b == 0) begin
        ifb.core_done = 1'b1;
        ifb.core_h0   = hfn(nreg_b);
      end
    end
    if (ifb.core_start[0]) begin
      nreg_b = ifb.core_nonce;
      cnt_b  = 4;
      bs_cyc.push_back(cyc);
      bs_non.push_back(ifb.core_nonce);
    end
  end

  task automatic check_zero(input string pfx);
    chk({pfx, "_busy"},       32'(ifa.busy),       32'd0);
    chk({pfx, "_done"},       32'(ifa.done),       32'd0);
    chk({pfx, "_core_start"}, 32'(ifa.core_start), 32'd0);
    chk({pfx, "_core_nonce"}, ifa.core_nonce,      32'd0);
    chk({pfx, "_res_valid"},  32'(ifa.res_valid),  32'd0);
    chk({pfx, "_res_idx"},    32'(ifa.res_idx),    32'd0);
    chk({pfx, "_res_data"},   ifa.res_data,        32'd0);
  endtask

  task automatic run_batch(input vec_t v, input int row);
    int          s0, ndone, nres, last_hs, done_cyc;
    logic        seen [16];
    logic        rdy;
    logic [7:0]  idx;
    s0 = starts_a; ndone = 0; nres = 0; last_hs = 0; done_cyc = 0;
    seen  = '{default: 1'b0};
    lat_a = v.lat;
    ifa.nonce_base = v.base;
    ifa.start      = 1'b1;
    step();
    ifa.start      = 1'b0;
    ifa.nonce_base = 32'h0;
    chk($sformatf("r%0d_busy_after_start", row), 32'(ifa.busy), 32'd1);
    chk($sformatf("r%0d_first_start_onehot", row), 32'($countones(ifa.core_start)), 32'd1);
    chk($sformatf("r%0d_first_nonce", row), ifa.core_nonce, v.base);
    for (int k = 0; k < 3000 && ndone == 0; k++) begin
      if (v.do_restart && k == 5) begin
        ifa.start      = 1'b1;
        ifa.nonce_base = v.rbase;
      end else begin
        ifa.start      = 1'b0;
        ifa.nonce_base = 32'h0;
      end
      case (v.rmode)
        0:       rdy = 1'b1;
        1:       rdy = ((cyc % 2) == 0);
        default: rdy = ($urandom_range(0, 1) == 1);
      endcase
      ifa.res_ready = rdy;
      if (ifa.done) begin
        ndone++;
        done_cyc = cyc;
        chk($sformatf("r%0d_busy_at_done", row), 32'(ifa.busy), 32'd1);
      end
      if (ifa.res_valid && rdy) begin
        idx = ifa.res_idx;
        chk($sformatf("r%0d_idx_range", row), 32'(idx < 8'd16), 32'd1);
        if (idx < 8'd16) begin
          chk($sformatf("r%0d_idx_dup", row), 32'(seen[idx[3:0]]), 32'd0);
          seen[idx[3:0]] = 1'b1;
        end
        chk($sformatf("r%0d_res_data", row), ifa.res_data, hfn(v.base + 32'(idx)));
        nres++;
        last_hs = cyc;
      end
      step();
    end
    ifa.start = 1'b0;
    chk($sformatf("r%0d_done_pulses", row), 32'(ndone), 32'd1);
    chk($sformatf("r%0d_done_latency", row), 32'(done_cyc - last_hs), 32'd1);
    chk($sformatf("r%0d_busy_idle", row), 32'(ifa.busy), 32'd0);
    chk($sformatf("r%0d_done_single", row), 32'(ifa.done), 32'd0);
    chk($sformatf("r%0d_results", row), 32'(nres), 32'd16);
    chk($sformatf("r%0d_starts", row), 32'(starts_a - s0), 32'd16);
    if (nlog_a.size() >= s0 + 16) begin
      chk($sformatf("r%0d_nonce0", row),  nlog_a[s0],      v.e0);
      chk($sformatf("r%0d_nonce1", row),  nlog_a[s0 + 1],  v.e1);
      chk($sformatf("r%0d_nonce2", row),  nlog_a[s0 + 2],  v.e2);
      chk($sformatf("r%0d_nonce3", row),  nlog_a[s0 + 3],  v.e3);
      chk($sformatf("r%0d_nonce15", row), nlog_a[s0 + 15], v.e15);
      for (int j = 4; j < 15; j++)
        chk($sformatf("r%0d_nonce%0d", row, j), nlog_a[s0 + j], v.base + 32'(j));
    end
  endtask

  initial begin
    vec_t tbl [4];
    int   s0, nres, ndone, done_b;
    int   hs_cyc [$];
    logic [7:0] hs_idx [$];

    tbl[0] = '{32'h0000_0000, 10, 0, 1'b0, 32'h0,
               32'h0000_0000, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 32'h0000_000F};
    tbl[1] = '{32'hFFFF_FFFE, 10, 0, 1'b0, 32'h0,
               32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 32'h0000_000D};
    tbl[2] = '{32'h1234_5678, 3, 1, 1'b0, 32'h0,
               32'h1234_5678, 32'h1234_5679, 32'h1234_567A, 32'h1234_567B, 32'h1234_5687};
    tbl[3] = '{32'h0000_0064, 7, 2, 1'b1, 32'hDEAD_0000,
               32'h0000_0064, 32'h0000_0065, 32'h0000_0066, 32'h0000_0067, 32'h0000_0073};

    ifa.start = 1'b0; ifa.nonce_base = 32'h0; ifa.res_ready = 1'b0;
    ifb.start = 1'b0; ifb.nonce_base = 32'h0; ifb.res_ready = 1'b0;

    repeat (3) @(posedge clk);
    #2;
    check_zero("reset");
    rst = 1'b0;
    step();

    for (int r = 0; r < 4; r++) run_batch(tbl[r], r);

    // Reset with exactly two cores running; their later completions must be ignored.
    lat_a = 10;
    s0 = starts_a;
    ifa.nonce_base = 32'h0000_0500;
    ifa.start = 1'b1;
    step();
    ifa.start = 1'b0;
    for (int k = 0; k < 20 && (starts_a - s0) < 2; k++) step();
    chk("midrst_two_running", 32'(starts_a - s0), 32'd2);
    rst = 1'b1;
    #1;
    check_zero("midrst");
    step();
    step();
    rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk("stale_res_valid", 32'(ifa.res_valid), 32'd0);
      chk("stale_busy", 32'(ifa.busy), 32'd0);
      step();
    end
    chk("stale_no_launch", 32'(starts_a - s0), 32'd2);

    // Fresh batch after reset: four simultaneous completions under 20 cycles of backpressure.
    hold_a = 1'b1;
    lat_a  = 5;
    ifa.res_ready = 1'b0;
    s0 = starts_a;
    ifa.nonce_base = 32'h0000_0040;
    ifa.start = 1'b1;
    step();
    ifa.start = 1'b0;
    for (int k = 0; k < 50 && (starts_a - s0) < 4; k++) step();
    chk("hold_four_starts", 32'(starts_a - s0), 32'd4);
    repeat (8) step();
    chk("hold_valid_before_done", 32'(ifa.res_valid), 32'd0);
    hold_a = 1'b0;
    step();
    for (int j = 0; j < 20; j++) begin
      chk("hold_res_valid", 32'(ifa.res_valid), 32'd1);
      chk("hold_res_idx", 32'(ifa.res_idx), 32'd0);
      chk("hold_res_data", ifa.res_data, hfn(32'h40));
      step();
    end
    chk("hold_no_core_start", 32'(starts_a - s0), 32'd4);
    ifa.res_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      chk("release_res_valid", 32'(ifa.res_valid), 32'd1);
      chk("release_res_idx", 32'(ifa.res_idx), 32'(j));
      chk("release_res_data", ifa.res_data, hfn(32'h40 + 32'(j)));
      step();
    end
    nres = 0; ndone = 0;
    for (int k = 0; k < 600 && ndone == 0; k++) begin
      if (ifa.done) ndone++;
      if (ifa.res_valid) begin
        chk("post_rst_res_data", ifa.res_data, hfn(32'h40 + 32'(ifa.res_idx)));
        nres++;
      end
      step();
    end
    chk("post_rst_results", 32'(nres), 32'd12);
    chk("post_rst_done", 32'(ndone), 32'd1);
    chk("post_rst_starts", 32'(starts_a - s0), 32'd16);

    // Single-core instance: launch, capture, drain strictly in sequence.
    ifb.res_ready  = 1'b1;
    ifb.nonce_base = 32'h0000_0777;
    ifb.start      = 1'b1;
    step();
    ifb.start      = 1'b0;
    done_b = -1;
    for (int k = 0; k < 300 && done_b < 0; k++) begin
      if (ifb.done) done_b = cyc;
      if (ifb.res_valid) begin
        hs_cyc.push_back(cyc);
        hs_idx.push_back(ifb.res_idx);
        chk("serial_res_data", ifb.res_data, hfn(32'h777 + 32'(ifb.res_idx)));
      end
      step();
    end
    chk("serial_starts", 32'(bs_cyc.size()), 32'd3);
    chk("serial_results", 32'(hs_cyc.size()), 32'd3);
    if (bs_cyc.size() == 3 && hs_cyc.size() == 3) begin
      for (int j = 0; j < 3; j++) begin
        chk("serial_nonce", bs_non[j], 32'h777 + 32'(j));
        chk("serial_idx", 32'(hs_idx[j]), 32'(j));
        chk("serial_start_before_result", 32'(bs_cyc[j] < hs_cyc[j]), 32'd1);
        if (j < 2)
          chk("serial_result_before_next_start", 32'(hs_cyc[j] < bs_cyc[j + 1]), 32'd1);
      end
      chk("serial_done_latency", 32'(done_b - hs_cyc[2]), 32'd1);
    end
    chk("serial_busy_idle", 32'(ifb.busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, checks %0d failures %0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
